// File: rtl/step_mon_pkg.sv
// Shared types and default timing constants for the STEP/DIR/EN_N receive monitor.
package step_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } step_mon_state_t;

  localparam int unsigned CLK_HZ            = 25_000_000;
  localparam int unsigned MIN_PULSE_DEFAULT = 25;      // 1 us at CLK_HZ
  localparam int unsigned DIR_SETUP_DEFAULT = 5;       // 200 ns at CLK_HZ
  localparam int unsigned TIMEOUT_DEFAULT   = CLK_HZ;  // 1 s without a step

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/step_dir_monitor_sync_edge.sv
// Two-flop synchronizer plus a delay flop; reports the synced level and its edges.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic delay_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_reg  <= RESET_VAL;
      sync_reg  <= RESET_VAL;
      delay_reg <= RESET_VAL;
    end else begin
      meta_reg  <= raw;
      sync_reg  <= meta_reg;
      delay_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign rise  = sync_reg & ~delay_reg;
  assign fall  = ~sync_reg & delay_reg;

endmodule

// File: rtl/step_dir_monitor.sv
// STEP/DIR/EN_N monitor: position, step period, stall and pulse-timing checks.
// Define STEP_MON_TIMING_CHECK_EN to build the width/DIR-setup checkers.
module step_dir_monitor
  import step_mon_pkg::*;
#(
  parameter int unsigned MIN_PULSE = MIN_PULSE_DEFAULT,
  parameter int unsigned DIR_SETUP = DIR_SETUP_DEFAULT,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT,
  parameter int unsigned POS_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        step_in,
  input  logic                        dir_in,
  input  logic                        en_n_in,
  input  logic                        clear_pos,
  input  logic                        clear_err,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        step_pulse,
  output logic [31:0]                 period,
  output logic                        period_valid,
  output logic                        stalled,
  output logic                        err_short_high,
  output logic                        err_short_low,
  output logic                        err_dir_setup
);

  logic [2:0] raw_vec, level_vec, rise_vec, fall_vec;
  assign raw_vec = {en_n_in, dir_in, step_in};

  // Lane 0 is STEP and resets high so a line held high through reset is not a rise.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    sync_edge #(.RESET_VAL((gi == 0) ? 1'b1 : 1'b0)) u_sync (
      .clock (clock),
      .reset (reset),
      .raw   (raw_vec[gi]),
      .level (level_vec[gi]),
      .rise  (rise_vec[gi]),
      .fall  (fall_vec[gi])
    );
  end

  logic step_rise, step_fall, dir_level, dir_change, en_n_level, counted_rise;
  assign step_rise    = rise_vec[0];
  assign step_fall    = fall_vec[0];
  assign dir_level    = level_vec[1];
  assign dir_change   = rise_vec[1] | fall_vec[1];
  assign en_n_level   = level_vec[2];
  assign counted_rise = step_rise & ~en_n_level;

  logic unused_sync;
  assign unused_sync = ^{level_vec[0], rise_vec[2], fall_vec[2]};

  step_mon_state_t state_reg, state_next;
  logic [31:0] cycle_cnt_reg;
  logic signed [POS_WIDTH-1:0] position_reg, position_next, position_base;
  logic [31:0] period_reg;
  logic period_valid_reg, step_pulse_reg, stalled_reg;
  logic period_load, stall_set;

  always_comb begin
    state_next  = state_reg;
    period_load = 1'b0;
    stall_set   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (counted_rise) state_next = HIGH;
      end
      HIGH: begin
        if (step_fall) begin
          state_next = LOW;
        end else if (cycle_cnt_reg >= 32'(TIMEOUT)) begin
          state_next = IDLE;
          stall_set  = 1'b1;
        end
      end
      LOW: begin
        // A rise landing exactly on the timeout still yields a period.
        if (counted_rise) begin
          state_next  = HIGH;
          period_load = 1'b1;
        end else if (cycle_cnt_reg >= 32'(TIMEOUT)) begin
          state_next = IDLE;
          stall_set  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    position_base = clear_pos ? '0 : position_reg;
    position_next = position_base;
    if (counted_rise) begin
      position_next = dir_level ? position_base + POS_WIDTH'(1)
                                : position_base - POS_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      cycle_cnt_reg    <= '0;
      position_reg     <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      step_pulse_reg   <= 1'b0;
      stalled_reg      <= 1'b1;
    end else begin
      state_reg        <= state_next;
      cycle_cnt_reg    <= counted_rise ? 32'd1 : sat_inc32(cycle_cnt_reg);
      position_reg     <= position_next;
      step_pulse_reg   <= counted_rise;
      period_valid_reg <= period_load;
      if (period_load) period_reg <= cycle_cnt_reg;
      if (counted_rise) stalled_reg <= 1'b0;
      else if (stall_set) stalled_reg <= 1'b1;
    end
  end

  assign position     = position_reg;
  assign step_pulse   = step_pulse_reg;
  assign period       = period_reg;
  assign period_valid = period_valid_reg;
  assign stalled      = stalled_reg;

`ifdef STEP_MON_TIMING_CHECK_EN
  localparam int unsigned PW = $clog2(MIN_PULSE + 1);
  localparam int unsigned DW = $clog2(DIR_SETUP + 1);

  logic [PW-1:0] high_cnt_reg, low_cnt_reg;
  logic [DW-1:0] dir_age_reg;
  logic err_short_high_reg, err_short_low_reg, err_dir_setup_reg;
  logic short_high, short_low, dir_violation;

  // Width counters restart on every edge so they always hold the width just ended.
  assign short_high    = (state_reg == HIGH) && step_fall && (high_cnt_reg < PW'(MIN_PULSE));
  assign short_low     = period_load && (low_cnt_reg < PW'(MIN_PULSE));
  assign dir_violation = counted_rise && (dir_age_reg < DW'(DIR_SETUP));

  always_ff @(posedge clock) begin
    if (reset) begin
      high_cnt_reg       <= '0;
      low_cnt_reg        <= '0;
      dir_age_reg        <= '0;
      err_short_high_reg <= 1'b0;
      err_short_low_reg  <= 1'b0;
      err_dir_setup_reg  <= 1'b0;
    end else begin
      if (step_rise) high_cnt_reg <= PW'(1);
      else if (high_cnt_reg != PW'(MIN_PULSE)) high_cnt_reg <= high_cnt_reg + PW'(1);
      if (step_fall) low_cnt_reg <= PW'(1);
      else if (low_cnt_reg != PW'(MIN_PULSE)) low_cnt_reg <= low_cnt_reg + PW'(1);
      if (dir_change) dir_age_reg <= '0;
      else if (dir_age_reg != DW'(DIR_SETUP)) dir_age_reg <= dir_age_reg + DW'(1);
      err_short_high_reg <= (err_short_high_reg & ~clear_err) | short_high;
      err_short_low_reg  <= (err_short_low_reg & ~clear_err) | short_low;
      err_dir_setup_reg  <= (err_dir_setup_reg & ~clear_err) | dir_violation;
    end
  end

  assign err_short_high = err_short_high_reg;
  assign err_short_low  = err_short_low_reg;
  assign err_dir_setup  = err_dir_setup_reg;
`else
  logic unused_timing;
  assign unused_timing  = ^{clear_err, dir_change, 32'(MIN_PULSE), 32'(DIR_SETUP)};
  assign err_short_high = 1'b0;
  assign err_short_low  = 1'b0;
  assign err_dir_setup  = 1'b0;
`endif

endmodule

// File: tb/tb_step_dir_monitor.sv
// Bench for step_dir_monitor: vector table, hand-written corner sequences and
// randomized pulse trains against a pulse-level reference model.
`timescale 1ns/1ps
module tb_step_dir_monitor;
  import step_mon_pkg::*;

  localparam int TB_TIMEOUT = 3000;
`ifdef STEP_MON_TIMING_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, step_in, dir_in, en_n_in, clear_pos, clear_err;
  logic [31:0] position, period;
  logic step_pulse, period_valid, stalled, err_short_high, err_short_low, err_dir_setup;

  step_dir_monitor #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .step_in        (step_in),
    .dir_in         (dir_in),
    .en_n_in        (en_n_in),
    .clear_pos      (clear_pos),
    .clear_err      (clear_err),
    .position       (position),
    .step_pulse     (step_pulse),
    .period         (period),
    .period_valid   (period_valid),
    .stalled        (stalled),
    .err_short_high (err_short_high),
    .err_short_low  (err_short_low),
    .err_dir_setup  (err_dir_setup)
  );

  always #20 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int sp_count = 0;
  int pv_count = 0;

  always @(posedge clock) begin
    #1;
    if (step_pulse) sp_count++;
    if (period_valid) pv_count++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(20);
    sp_count = 0;
    pv_count = 0;
  endtask

  task automatic pulse(input int hi, input int lo);
    step_in = 1'b1;
    tick(hi);
    step_in = 1'b0;
    tick(lo);
  endtask

  typedef struct {
    int n; int hi; int lo; int dir; int en_n;
    int exp_pos; int exp_sp; int exp_pv; int exp_period; int exp_ehi; int exp_elo;
  } vec_t;
  vec_t vecs[9];

  // Reference model state for the random section
  bit          has_prev;
  int          gap, prev_lo, m_sp, m_pv;
  logic [31:0] m_pos, m_period;
  bit          m_ehi, m_elo;

  initial begin
    reset = 1'b1; step_in = 1'b0; dir_in = 1'b1; en_n_in = 1'b0;
    clear_pos = 1'b0; clear_err = 1'b0;

    vecs[0] = '{10, 50, 50, 1, 0, 10, 10, 9, 100, 0, 0};
    vecs[1] = '{ 5, 50, 50, 0, 0, -5,  5, 4, 100, 0, 0};
    vecs[2] = '{ 3, 10, 90, 1, 0,  3,  3, 2, 100, 1, 0};
    vecs[3] = '{ 3, 90, 10, 1, 0,  3,  3, 2, 100, 0, 1};
    vecs[4] = '{ 3, 24, 76, 0, 0, -3,  3, 2, 100, 1, 0};
    vecs[5] = '{ 3, 25, 25, 1, 0,  3,  3, 2,  50, 0, 0};
    vecs[6] = '{ 3, 76, 24, 1, 0,  3,  3, 2, 100, 0, 1};
    vecs[7] = '{ 4, 30, 30, 1, 1,  0,  0, 0,   0, 0, 0};
    vecs[8] = '{ 4,  2,  2, 1, 0,  4,  4, 3,   4, 1, 1};

    // Reset values
    tick(3);
    chk("reset position", position, 32'd0);
    chk("reset period", period, 32'd0);
    chk("reset step_pulse", 32'(step_pulse), 32'd0);
    chk("reset period_valid", 32'(period_valid), 32'd0);
    chk("reset stalled", 32'(stalled), 32'd1);
    chk("reset err flags", 32'({err_short_high, err_short_low, err_dir_setup}), 32'd0);

    // Table-driven pulse trains, each from a fresh reset
    for (int i = 0; i < 9; i++) begin
      int e_hi, e_lo;
      dir_in = vecs[i].dir[0];
      en_n_in = vecs[i].en_n[0];
      step_in = 1'b0;
      do_reset();
      for (int k = 0; k < vecs[i].n; k++) pulse(vecs[i].hi, vecs[i].lo);
      tick(10);
      e_hi = (vecs[i].exp_ehi != 0 && CHK) ? 1 : 0;
      e_lo = (vecs[i].exp_elo != 0 && CHK) ? 1 : 0;
      chk($sformatf("vec%0d position", i), position, 32'(vecs[i].exp_pos));
      chk($sformatf("vec%0d step_pulse count", i), 32'(sp_count), 32'(vecs[i].exp_sp));
      chk($sformatf("vec%0d period_valid count", i), 32'(pv_count), 32'(vecs[i].exp_pv));
      chk($sformatf("vec%0d period", i), period, 32'(vecs[i].exp_period));
      chk($sformatf("vec%0d err_short_high", i), 32'(err_short_high), 32'(e_hi));
      chk($sformatf("vec%0d err_short_low", i), 32'(err_short_low), 32'(e_lo));
      chk($sformatf("vec%0d err_dir_setup", i), 32'(err_dir_setup), 32'd0);
      clear_err = 1'b1;
      tick(1);
      clear_err = 1'b0;
      chk($sformatf("vec%0d flags after clear_err", i),
          32'({err_short_high, err_short_low, err_dir_setup}), 32'd0);
    end

    // Latency of the first counted rise after reset
    dir_in = 1'b1; en_n_in = 1'b0; step_in = 1'b0;
    do_reset();
    step_in = 1'b1;
    tick(2);
    chk("latency step_pulse early", 32'(step_pulse), 32'd0);
    tick(1);
    chk("latency step_pulse", 32'(step_pulse), 32'd1);
    chk("latency position", position, 32'd1);
    chk("first rise period_valid", 32'(period_valid), 32'd0);
    tick(1);
    chk("step_pulse one cycle", 32'(step_pulse), 32'd0);
    tick(26);
    step_in = 1'b0;
    tick(70);
    clear_pos = 1'b1;
    tick(1);
    clear_pos = 1'b0;
    chk("clear_pos alone", position, 32'd0);

    // Negative count, then clear_pos coinciding with a counted rise
    dir_in = 1'b0;
    tick(30);
    for (int k = 0; k < 5; k++) pulse(50, 50);
    chk("ccw five steps", position, 32'hFFFF_FFFB);
    dir_in = 1'b1;
    tick(30);
    step_in = 1'b1;
    tick(2);
    clear_pos = 1'b1;
    tick(1);
    clear_pos = 1'b0;
    chk("clear_pos with step", position, 32'd1);
    tick(47);
    step_in = 1'b0;
    tick(50);
    chk("clear_pos with step settled", position, 32'd1);

    // DIR changes two clocks before a rise
    dir_in = 1'b0;
    tick(2);
    step_in = 1'b1;
    tick(40);
    chk("dir setup flag", 32'(err_dir_setup), 32'(CHK));
    chk("dir setup new direction", position, 32'd0);
    step_in = 1'b0;
    tick(60);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("dir setup cleared", 32'(err_dir_setup), 32'd0);

    // Disabled rises, then stall and recovery
    dir_in = 1'b1;
    en_n_in = 1'b1;
    tick(30);
    sp_count = 0;
    pv_count = 0;
    for (int k = 0; k < 4; k++) pulse(50, 50);
    chk("disabled position", position, 32'd0);
    chk("disabled step_pulse count", 32'(sp_count), 32'd0);
    chk("not yet stalled", 32'(stalled), 32'd0);
    tick(TB_TIMEOUT);
    chk("stalled after timeout", 32'(stalled), 32'd1);
    en_n_in = 1'b0;
    tick(30);
    pulse(50, 50);
    chk("stall cleared", 32'(stalled), 32'd0);
    chk("no period after stall", 32'(pv_count), 32'd0);
    chk("position after stall", position, 32'd1);
    chk("step after stall counted", 32'(sp_count), 32'd1);

    // Reset while STEP is held high
    step_in = 1'b1;
    tick(10);
    reset = 1'b1;
    tick(3);
    chk("reset mid-pulse position", position, 32'd0);
    reset = 1'b0;
    sp_count = 0;
    pv_count = 0;
    tick(30);
    chk("held high not counted", 32'(sp_count), 32'd0);
    step_in = 1'b0;
    tick(30);
    pulse(50, 50);
    chk("post-reset pulse count", 32'(sp_count), 32'd1);
    chk("post-reset position", position, 32'd1);
    chk("post-reset no period_valid", 32'(pv_count), 32'd0);

    // Randomized pulse trains against the pulse-level model
    dir_in = 1'($urandom_range(0, 1));
    en_n_in = 1'b0;
    step_in = 1'b0;
    do_reset();
    has_prev = 1'b0; gap = 0; prev_lo = 0; m_sp = 0; m_pv = 0;
    m_pos = '0; m_period = '0; m_ehi = 1'b0; m_elo = 1'b0;
    for (int p = 0; p < 60; p++) begin
      int hi, lo;
      logic ndir, nen;
      hi   = int'($urandom_range(2, 40));
      lo   = int'($urandom_range(8, 60));
      ndir = 1'($urandom_range(0, 1));
      nen  = ($urandom_range(0, 3) == 0);
      if (!en_n_in) begin
        if (has_prev && gap <= TB_TIMEOUT) begin
          m_pv++;
          m_period = 32'(gap);
          if (prev_lo < int'(MIN_PULSE_DEFAULT)) m_elo = 1'b1;
        end
        m_pos = dir_in ? m_pos + 32'd1 : m_pos - 32'd1;
        m_sp++;
        if (hi < int'(MIN_PULSE_DEFAULT)) m_ehi = 1'b1;
        has_prev = 1'b1;
        gap = 0;
      end
      step_in = 1'b1;
      tick(hi);
      step_in = 1'b0;
      dir_in = ndir;
      en_n_in = nen;
      tick(lo - 1);
      gap += hi + lo;
      prev_lo = lo;
      chk($sformatf("rand%0d position", p), position, m_pos);
      chk($sformatf("rand%0d step_pulse count", p), 32'(sp_count), 32'(m_sp));
      chk($sformatf("rand%0d period_valid count", p), 32'(pv_count), 32'(m_pv));
      chk($sformatf("rand%0d period", p), period, m_period);
      chk($sformatf("rand%0d err_short_high", p), 32'(err_short_high), 32'(m_ehi & CHK));
      chk($sformatf("rand%0d err_short_low", p), 32'(err_short_low), 32'(m_elo & CHK));
      chk($sformatf("rand%0d err_dir_setup", p), 32'(err_dir_setup), 32'd0);
      if ($urandom_range(0, 2) == 0) begin
        clear_err = 1'b1;
        m_ehi = 1'b0;
        m_elo = 1'b0;
      end
      tick(1);
      clear_err = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/step_dir_monitor.md
# step_dir_monitor

Receive-side monitor for the STEP/DIR/EN_N stepper interface. It samples the three driver-facing signals and maintains a signed microstep position, measures the step period, and flags pulse-timing violations against the A4988 minimums. It sits beside the motor driver on the same STEP/DIR/EN_N pins, or on the input of an external step/dir source, in the 25 MHz clock domain.

## Interface
- `MIN_PULSE`, 25: minimum STEP high and STEP low width in clocks (1 µs at 25 MHz).
- `DIR_SETUP`, 5: minimum clocks DIR must be stable before a STEP rising edge (200 ns).
- `TIMEOUT`, 25_000_000: clocks without a STEP rise before `stalled` is declared.
- `POS_WIDTH`, 32: position width.
- `clock` input 1: sole clock, 25 MHz.
- `reset` input 1: synchronous, active-high reset.
- `step_in` input 1: asynchronous STEP line.
- `dir_in` input 1: asynchronous DIR line; 1 = clockwise, 0 = counter-clockwise.
- `en_n_in` input 1: asynchronous active-low driver enable.
- `clear_pos` input 1: one-cycle request to zero `position`.
- `clear_err` input 1: one-cycle request to clear the sticky error flags.
- `position` output POS_WIDTH: signed accumulated microsteps.
- `step_pulse` output 1: one-cycle strobe for each counted step.
- `period` output 32: clocks between the last two counted rises.
- `period_valid` output 1: one-cycle strobe when `period` updates.
- `stalled` output 1: no counted rise within `TIMEOUT` clocks.
- `err_short_high`, `err_short_low`, `err_dir_setup` output 1 each: sticky timing-violation flags.

## Operation
- Each input passes through a 2-flop synchronizer, followed by a third flop for edge detection.
  - step stages reset to 1, so a STEP held high through reset is not counted.
  - dir and en_n stages reset to 0.
- rise = synced step & ~delayed step. fall is the complement.
- A rise is counted only when synced en_n = 0. Rises while disabled are ignored entirely: no position change, no period, no checks.
- Position update on a counted rise: +1 if synced dir = 1, else −1.
  - Two's-complement wrap at both limits, no saturation.
- `clear_pos` zeroes `position`. If `clear_pos` and a counted rise occur in the same cycle, the result is ±1 (clear first, then count).
- FSM states:
  - IDLE: no reference rise. Reset state.
  - HIGH: counting the high width.
  - LOW: counting the low width and the period.
- FSM transitions:
  - IDLE→HIGH on a counted rise. No `period_valid`.
  - HIGH→LOW on fall.
  - LOW→HIGH on a counted rise. `period` ← cycle counter, `period_valid` = 1.
  - HIGH or LOW→IDLE when the cycle counter reaches `TIMEOUT`. `stalled` ← 1.
  - Any state→IDLE on reset.
- Cycle counter:
  - Set to 1 on each counted rise; increments every cycle otherwise.
  - Saturates at 2^32−1.
  - `period` is therefore the exact clock distance between consecutive counted rises.
- `stalled` clears on any counted rise.
- Error flags (see Configuration):
  - `err_short_high`: a fall occurs with high count < `MIN_PULSE`.
  - `err_short_low`: in LOW, a counted rise occurs with low count < `MIN_PULSE`. Not checked on IDLE→HIGH.
  - `err_dir_setup`: a counted rise occurs with DIR age < `DIR_SETUP`. DIR age resets to 0 on any synced DIR change and saturates at `DIR_SETUP`.
  - All flags are sticky until `clear_err`. A new violation in the same cycle as `clear_err` leaves the flag set.

## Timing
- `step_pulse`, the `position` update and `period_valid` are asserted together, registered, 3 clock edges after the first edge that samples `step_in` high.
- A pulse must be ≥ 2 clocks high and ≥ 2 clocks low to be seen reliably. Narrower pulses may be dropped and are not required to be counted.
- `clear_pos` and `clear_err` take effect on the next edge.
- Reset values:
  - `position` = 0, `period` = 0.
  - `step_pulse`, `period_valid` and all error flags = 0.
  - `stalled` = 1.
  - FSM in IDLE, counters = 0.
- Reset mid-pulse: all state is discarded. The first counted rise after reset produces no `period_valid`.

## Configuration
- `STEP_MON_TIMING_CHECK_EN`:
  - Defined: the high-width, low-width and DIR-age counters are present, and the three error flags operate as specified.
  - Undefined: those counters are removed and the error flags are tied to 0.
- Position, period and stall behaviour is identical in both builds.

## Structure
- Package `step_mon_pkg` holds:
  - the state enum `step_mon_state_t` (IDLE, HIGH, LOW);
  - `CLK_HZ` = 25_000_000;
  - the default `MIN_PULSE`, `DIR_SETUP` and `TIMEOUT` constants.
- Sub-module `sync_edge`: 2-flop synchronizer plus delay flop with a reset-value parameter, outputting level, rise and fall. It is instantiated three times.

## Test plan
- 10 rises at 100-clock period, dir=1, en_n=0 → `position`=10; 9 `period_valid` strobes with `period`=100; no errors.
- 5 rises with dir=0 from position 0 → `position`=−5 (0xFFFFFFFB). Then `clear_pos` on the same cycle as a dir=1 step → `position`=1.
- STEP high for 10 clocks, low for 90 → `err_short_high`=1, `err_short_low`=0. `clear_err` → 0.
- DIR toggles 2 clocks before a rise → `err_dir_setup`=1. Position moves in the new direction.
- en_n=1 with 4 rises → `position` unchanged, no `step_pulse`. Then no rise for `TIMEOUT` clocks → `stalled`=1; the next rise clears `stalled` without `period_valid`.
- Assert `reset` while STEP is held high, release with STEP still high → no count. The next full pulse counts exactly once.
